// File: rtl/posedge_input_conditioner_pkg.sv
// Shared types and limits for the posedge counter input conditioner.
package posedge_cond_pkg;

  localparam int FILT_W_DEFAULT  = 4;
  localparam int SYNC_STAGES_MIN = 2;
  localparam int SYNC_STAGES_MAX = 4;

  typedef logic [FILT_W_DEFAULT-1:0] filt_cnt_t;

endpackage

// File: rtl/posedge_input_conditioner_if.sv
// Bundle of the conditioner's per-channel control inputs and conditioned outputs.
interface posedge_input_conditioner_if #(
  parameter int N_CH   = 8,
  parameter int FILT_W = 4
);
  logic [N_CH-1:0]   input_signals;
  logic [FILT_W-1:0] filt_len;
  logic [N_CH-1:0]   ch_enable;
  logic [N_CH-1:0]   glitch_clr;
  logic [N_CH-1:0]   sig_level;
  logic [N_CH-1:0]   rise_pulse;
  logic [N_CH-1:0]   fall_pulse;
  logic [N_CH-1:0]   glitch_seen;

  modport master (
    output input_signals, filt_len, ch_enable, glitch_clr,
    input  sig_level, rise_pulse, fall_pulse, glitch_seen
  );

  modport slave (
    input  input_signals, filt_len, ch_enable, glitch_clr,
    output sig_level, rise_pulse, fall_pulse, glitch_seen
  );
endinterface

// File: rtl/posedge_input_conditioner_channel.sv
// One channel: synchroniser chain, deglitch filter, edge strobes and sticky glitch flag.
module posedge_cond_channel #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_W      = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              din,
  input  logic [FILT_W-1:0] filt_len,
  input  logic              ch_enable,
  input  logic              glitch_clr,
  output logic              sig_level,
  output logic              rise_pulse,
  output logic              fall_pulse,
  output logic              glitch_seen
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [FILT_W-1:0]      cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   glitch_q, glitch_d;
  logic                   s;
  logic                   glitch_set;

  assign s = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d     = {sync_q[SYNC_STAGES-2:0], din};
    level_d    = level_q;
    cnt_d      = cnt_q;
    rise_d     = 1'b0;
    fall_d     = 1'b0;
    glitch_set = 1'b0;
    if (s == level_q) begin
      // Input fell back before being accepted: that run was a glitch.
      cnt_d      = '0;
      glitch_set = (cnt_q != '0);
    end else if (cnt_q >= filt_len) begin
      level_d = s;
      cnt_d   = '0;
      rise_d  = s & ch_enable;
      fall_d  = ~s & ch_enable;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
    glitch_d = glitch_set | (glitch_q & ~glitch_clr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= '0;
      cnt_q    <= '0;
      level_q  <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      glitch_q <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      cnt_q    <= cnt_d;
      level_q  <= level_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      glitch_q <= glitch_d;
    end
  end

  assign sig_level   = level_q;
  assign rise_pulse  = rise_q;
  assign fall_pulse  = fall_q;
  assign glitch_seen = glitch_q;

endmodule

// File: rtl/posedge_input_conditioner.sv
// Front end of the posedge counter: N_CH independent synchronise-and-deglitch channels.
module posedge_input_conditioner
  import posedge_cond_pkg::*;
#(
  parameter int N_CH        = 8,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_W      = FILT_W_DEFAULT
) (
  input  logic                        S_AXI_ACLK,
  input  logic                        S_AXI_ARESETN,
  posedge_input_conditioner_if.slave  bus
);

  if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_sync
    $error("posedge_input_conditioner: SYNC_STAGES must be in 2..4");
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    posedge_cond_channel #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILT_W      (FILT_W)
    ) u_ch (
      .clk         (S_AXI_ACLK),
      .rst_n       (S_AXI_ARESETN),
      .din         (bus.input_signals[i]),
      .filt_len    (bus.filt_len),
      .ch_enable   (bus.ch_enable[i]),
      .glitch_clr  (bus.glitch_clr[i]),
      .sig_level   (bus.sig_level[i]),
      .rise_pulse  (bus.rise_pulse[i]),
      .fall_pulse  (bus.fall_pulse[i]),
      .glitch_seen (bus.glitch_seen[i])
    );
  end

endmodule

// File: tb/tb_posedge_input_conditioner.sv
// Bench for posedge_input_conditioner: directed vector table, corner sequences, random vs model.
module tb_posedge_input_conditioner;
  import posedge_cond_pkg::*;

  localparam int N_CH = 8;
  localparam int SS   = 2;
  localparam int FW   = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   edge_no = 0;

  posedge_input_conditioner_if #(.N_CH(N_CH), .FILT_W(FW)) bus ();

  posedge_input_conditioner #(.N_CH(N_CH), .SYNC_STAGES(SS), .FILT_W(FW)) dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESETN (rst_n),
    .bus           (bus)
  );

  always #5 clk = ~clk;

  // Reference model: delay line of raw samples plus per-channel run length of disagreement.
  logic [N_CH-1:0] hist[$];
  logic [N_CH-1:0] m_level, m_rise, m_fall, m_glitch;
  int              run[N_CH];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", name, edge_no, act, exp);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    for (int k = 0; k < SS; k++) hist.push_back('0);
    m_level = '0; m_rise = '0; m_fall = '0; m_glitch = '0;
    for (int c = 0; c < N_CH; c++) run[c] = 0;
  endtask

  task automatic model_edge();
    logic [N_CH-1:0] s, nr, nf, ng;
    s  = hist.pop_front();
    hist.push_back(bus.input_signals);
    nr = '0; nf = '0;
    ng = m_glitch & ~bus.glitch_clr;
    for (int c = 0; c < N_CH; c++) begin
      if (s[c] == m_level[c]) begin
        if (run[c] > 0) ng[c] = 1'b1;
        run[c] = 0;
      end else if (run[c] >= int'(bus.filt_len)) begin
        m_level[c] = s[c];
        run[c] = 0;
        nr[c] = s[c] & bus.ch_enable[c];
        nf[c] = ~s[c] & bus.ch_enable[c];
      end else begin
        run[c] = run[c] + 1;
      end
    end
    m_rise = nr; m_fall = nf; m_glitch = ng;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    edge_no++;
    check("level", 32'(bus.sig_level),   32'(m_level));
    check("rise",  32'(bus.rise_pulse),  32'(m_rise));
    check("fall",  32'(bus.fall_pulse),  32'(m_fall));
    check("glitch",32'(bus.glitch_seen), 32'(m_glitch));
  endtask

  // Asynchronous assert between edges, release on a falling edge.
  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_level",  32'(bus.sig_level),   32'h0);
    check("rst_rise",   32'(bus.rise_pulse),  32'h0);
    check("rst_fall",   32'(bus.fall_pulse),  32'h0);
    check("rst_glitch", 32'(bus.glitch_seen), 32'h0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    edge_no = 0;
  endtask

  typedef struct {
    int ch; int fl; int hold; bit en;
    int rise_edge; int n_rise; bit glitch; bit lvl_seen;
  } vec_t;

  vec_t tbl[10];

  initial begin
    logic [N_CH-1:0] one;
    filt_cnt_t       fl_rand;
    int first, nr, nf;
    bit lvl;
    one = 1;

    tbl[0] = '{0, 0, 10, 1'b1, 3,  1, 1'b0, 1'b1};
    tbl[1] = '{1, 3,  3, 1'b1, 0,  0, 1'b1, 1'b0};
    tbl[2] = '{1, 3,  4, 1'b1, 6,  1, 1'b0, 1'b1};
    tbl[3] = '{2, 0,  5, 1'b0, 0,  0, 1'b0, 1'b1};
    tbl[4] = '{4, 2,  2, 1'b1, 0,  0, 1'b1, 1'b0};
    tbl[5] = '{5, 2,  3, 1'b1, 5,  1, 1'b0, 1'b1};
    tbl[6] = '{6, 15, 16, 1'b1, 18, 1, 1'b0, 1'b1};
    tbl[7] = '{7, 15, 15, 1'b1, 0,  0, 1'b1, 1'b0};
    tbl[8] = '{3, 1,  1, 1'b1, 0,  0, 1'b1, 1'b0};
    tbl[9] = '{6, 0,  1, 1'b1, 3,  1, 1'b0, 1'b1};

    bus.input_signals = '0;
    bus.filt_len      = '0;
    bus.ch_enable     = '1;
    bus.glitch_clr    = '0;
    model_reset();

    for (int t = 0; t < 10; t++) begin
      bus.input_signals = '0;
      bus.filt_len      = FW'(tbl[t].fl);
      bus.ch_enable     = tbl[t].en ? '1 : '0;
      do_reset();
      bus.input_signals = one << tbl[t].ch;
      first = 0; nr = 0; lvl = 1'b0;
      for (int i = 0; i < tbl[t].hold + 30; i++) begin
        if (i == tbl[t].hold) bus.input_signals = '0;
        step();
        if (bus.rise_pulse[tbl[t].ch]) begin
          nr++;
          if (first == 0) first = edge_no;
        end
        if (bus.sig_level[tbl[t].ch]) lvl = 1'b1;
      end
      check($sformatf("vec%0d_rise_edge", t), 32'(first), 32'(tbl[t].rise_edge));
      check($sformatf("vec%0d_n_rise", t),    32'(nr),    32'(tbl[t].n_rise));
      check($sformatf("vec%0d_glitch", t),    32'(bus.glitch_seen[tbl[t].ch]), 32'(tbl[t].glitch));
      check($sformatf("vec%0d_level", t),     32'(lvl),   32'(tbl[t].lvl_seen));
    end

    // Masked strobes while the level still tracks, then re-enable.
    bus.input_signals = '0; bus.filt_len = '0; bus.ch_enable = ~(one << 2);
    do_reset();
    bus.input_signals = one << 2;
    nr = 0; nf = 0;
    for (int i = 0; i < 5; i++) begin step(); nr += int'(bus.rise_pulse[2]); end
    check("mask_level_hi", 32'(bus.sig_level[2]), 32'h1);
    bus.input_signals = '0;
    for (int i = 0; i < 5; i++) begin step(); nf += int'(bus.fall_pulse[2]); end
    check("mask_level_lo", 32'(bus.sig_level[2]), 32'h0);
    check("mask_strobes", 32'(nr + nf), 32'h0);
    bus.ch_enable = '1;
    bus.input_signals = one << 2;
    step(); step();
    check("reen_rise_early", 32'(bus.rise_pulse[2]), 32'h0);
    step();
    check("reen_rise", 32'(bus.rise_pulse[2]), 32'h1);

    // All channels switching together.
    bus.input_signals = '0; bus.filt_len = '0; bus.ch_enable = '1;
    do_reset();
    bus.input_signals = '1;
    step(); step();
    check("all_rise_early", 32'(bus.rise_pulse), 32'h0);
    step();
    check("all_rise", 32'(bus.rise_pulse), 32'hFF);
    step();
    check("all_rise_once", 32'(bus.rise_pulse), 32'h0);
    for (int i = 0; i < 17; i++) step();
    bus.input_signals = '0;
    step(); step(); step();
    check("all_fall", 32'(bus.fall_pulse), 32'hFF);

    // Filter length shortened mid-count, then glitch flag set/clear priority.
    bus.input_signals = '0; bus.filt_len = 4'd15;
    do_reset();
    bus.input_signals = one << 3;
    for (int i = 0; i < 10; i++) step();
    check("shrink_before", 32'(bus.sig_level[3]), 32'h0);
    bus.filt_len = 4'd4;
    step();
    check("shrink_level", 32'(bus.sig_level[3]), 32'h1);
    check("shrink_rise",  32'(bus.rise_pulse[3]), 32'h1);
    for (int g = 0; g < 2; g++) begin
      bus.input_signals = '0;
      step(); step();
      bus.input_signals = one << 3;
      step();
      if (g == 1) bus.glitch_clr = one << 3;
      step();
      bus.glitch_clr = '0;
      step();
      check($sformatf("glitch_seen_%0d", g), 32'(bus.glitch_seen[3]), 32'h1);
    end
    bus.glitch_clr = one << 3;
    step();
    bus.glitch_clr = '0;
    check("glitch_clr", 32'(bus.glitch_seen[3]), 32'h0);

    // Reset in the middle of a count, inputs high across release.
    bus.input_signals = '1; bus.filt_len = '0;
    do_reset();
    for (int i = 0; i < 4; i++) step();
    check("pre_rst_level", 32'(bus.sig_level), 32'hFF);
    bus.filt_len = 4'd3; bus.input_signals = '0;
    step(); step(); step();
    bus.input_signals = '1;
    do_reset();
    first = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (bus.rise_pulse[0] && first == 0) first = edge_no;
    end
    check("post_rst_rise_edge", 32'(first), 32'd6);

    // Random traffic against the model.
    bus.input_signals = '0; bus.ch_enable = '1; bus.filt_len = '0;
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int c = 0; c < N_CH; c++)
        if ($urandom_range(0, 3) == 0) bus.input_signals[c] = ~bus.input_signals[c];
      if (cyc % 50 == 0) begin
        fl_rand = filt_cnt_t'($urandom_range(0, 6));
        bus.filt_len  = fl_rand;
        bus.ch_enable = N_CH'($urandom | $urandom);
      end
      bus.glitch_clr = N_CH'($urandom & $urandom & $urandom);
      if (cyc == 1500) do_reset();
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
